// File: rtl/icache_miss_queue.sv
// icache_miss_queue: multi-entry miss queue between the icache and memory.
// Demand misses and prefetches are merged by line and allocated in FIFO order.
// Reads go to memory in allocation order and refills come back in that order.
// A demand that hits a queued prefetch upgrades the entry to demand.
// Optional feature macro: ICACHE_MISS_Q_PERF_EN adds saturating perf counters.
module icache_miss_queue #(
    parameter int unsigned PLEN       = 32,
    parameter int unsigned LINE_WIDTH = 512,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned OFFSET_W   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  dmd_valid_i,
    output logic                  dmd_ready_o,
    input  logic [PLEN-1:0]       dmd_addr_i,
    input  logic                  pf_valid_i,
    output logic                  pf_ready_o,
    input  logic [PLEN-1:0]       pf_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PLEN-1:0]       mem_req_addr_o,
    output logic                  mem_req_pf_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
    output logic                  refill_valid_o,
    output logic [PLEN-1:0]       refill_addr_o,
    output logic [LINE_WIDTH-1:0] refill_data_o,
    output logic                  refill_pf_o,
    output logic                  busy_o
`ifdef ICACHE_MISS_Q_PERF_EN
    ,
    output logic [31:0]           perf_merge_o,
    output logic [31:0]           perf_pf_drop_o,
    output logic [31:0]           perf_full_o
`endif
);

    localparam int unsigned LineW = PLEN - OFFSET_W;
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic [1:0] {StFree, StPend, StIssued} ent_state_e;

    ent_state_e                r_state [DEPTH];
    logic [LineW-1:0]          r_line  [DEPTH];
    logic [DEPTH-1:0]          r_pf;
    logic [PtrW-1:0]           r_head;
    logic [PtrW-1:0]           r_iss;
    logic [PtrW-1:0]           r_tail;
    logic [CntW-1:0]           r_count;
    logic                      r_req_valid;
    logic [LineW-1:0]          r_req_line;
    logic                      r_req_pf;
    logic                      r_refill_valid;
    logic [LineW-1:0]          r_refill_line;
    logic [LINE_WIDTH-1:0]     r_refill_data;
    logic                      r_refill_pf;

    logic [LineW-1:0]          w_dmd_line;
    logic [LineW-1:0]          w_pf_line;
    logic                      w_rsp_fire;
    logic                      w_req_fire;
    logic [DEPTH-1:0]          w_dmd_hit;
    logic [DEPTH-1:0]          w_pf_hit;
    logic [CntW-1:0]           w_free;
    logic                      w_dmd_ready;
    logic                      w_pf_ready;
    logic                      w_dmd_alloc;
    logic                      w_pf_alloc;
    logic                      w_alloc;
    logic [LineW-1:0]          w_alloc_line;
    logic [PtrW-1:0]           w_iss_next;
    logic                      w_unused;

    assign w_dmd_line = dmd_addr_i[PLEN-1:OFFSET_W];
    assign w_pf_line  = pf_addr_i[PLEN-1:OFFSET_W];
    assign w_unused   = ^{dmd_addr_i[OFFSET_W-1:0], pf_addr_i[OFFSET_W-1:0]};

    // A response only completes the head when that entry has actually been issued.
    assign w_rsp_fire = mem_rsp_valid_i && (r_state[r_head] == StIssued);
    assign w_req_fire = r_req_valid && mem_req_ready_i;
    assign w_iss_next = r_iss + 1'b1;

    // The slot freed by a completing head is usable by an allocation in the same cycle.
    assign w_free = CntW'(DEPTH) - r_count + CntW'(w_rsp_fire);

    // Line match against live entries; the completing head no longer counts.
    always_comb begin
        w_dmd_hit = '0;
        w_pf_hit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] != StFree && !(w_rsp_fire && PtrW'(i) == r_head)) begin
                w_dmd_hit[i] = (r_line[i] == w_dmd_line);
                w_pf_hit[i]  = (r_line[i] == w_pf_line);
            end
        end
    end

    // Acceptance: demand wins; a concurrent prefetch only rides along on the demand line.
    always_comb begin
        w_dmd_ready  = (|w_dmd_hit) || (w_free != '0);
        w_pf_ready   = dmd_valid_i ? ((w_pf_line == w_dmd_line) && w_dmd_ready)
                                   : ((|w_pf_hit) || (w_free >= CntW'(2)));
        w_dmd_alloc  = dmd_valid_i && !(|w_dmd_hit) && (w_free != '0);
        w_pf_alloc   = !dmd_valid_i && pf_valid_i && !(|w_pf_hit) && (w_free >= CntW'(2));
        w_alloc      = w_dmd_alloc || w_pf_alloc;
        w_alloc_line = w_dmd_alloc ? w_dmd_line : w_pf_line;
    end

    // Entry array, pointers, request register and refill register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= StFree;
                r_line[i]  <= '0;
            end
            r_pf           <= '0;
            r_head         <= '0;
            r_iss          <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_req_valid    <= 1'b0;
            r_req_line     <= '0;
            r_req_pf       <= 1'b0;
            r_refill_valid <= 1'b0;
            r_refill_line  <= '0;
            r_refill_data  <= '0;
            r_refill_pf    <= 1'b0;
        end else begin
            if (dmd_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_dmd_hit[i]) begin
                        r_pf[i] <= 1'b0;
                    end
                end
            end
            if (w_req_fire) begin
                r_state[r_iss] <= StIssued;
                r_iss          <= w_iss_next;
            end
            if (w_rsp_fire) begin
                r_state[r_head] <= StFree;
                r_head          <= r_head + 1'b1;
            end
            // Allocation is last so it wins if it reuses the slot freed this cycle.
            if (w_alloc) begin
                r_state[r_tail] <= StPend;
                r_line[r_tail]  <= w_alloc_line;
                r_pf[r_tail]    <= w_pf_alloc;
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= r_count + CntW'(w_alloc) - CntW'(w_rsp_fire);

            // Request for the next pending entry is presented one cycle after it is pending.
            if (w_req_fire) begin
                r_req_valid <= (r_state[w_iss_next] == StPend);
                r_req_line  <= r_line[w_iss_next];
                r_req_pf    <= r_pf[w_iss_next];
            end else if (!r_req_valid && r_state[r_iss] == StPend) begin
                r_req_valid <= 1'b1;
                r_req_line  <= r_line[r_iss];
                r_req_pf    <= r_pf[r_iss];
            end

            r_refill_valid <= w_rsp_fire;
            if (w_rsp_fire) begin
                r_refill_line <= r_line[r_head];
                r_refill_data <= mem_rsp_data_i;
                r_refill_pf   <= r_pf[r_head];
            end
        end
    end

    assign dmd_ready_o     = w_dmd_ready;
    assign pf_ready_o      = w_pf_ready;
    assign mem_req_valid_o = r_req_valid;
    assign mem_req_addr_o  = {r_req_line, {OFFSET_W{1'b0}}};
    assign mem_req_pf_o    = r_req_pf;
    assign refill_valid_o  = r_refill_valid;
    assign refill_addr_o   = {r_refill_line, {OFFSET_W{1'b0}}};
    assign refill_data_o   = r_refill_data;
    assign refill_pf_o     = r_refill_pf;
    assign busy_o          = (r_count != '0);

`ifdef ICACHE_MISS_Q_PERF_EN
    logic [31:0] r_perf_merge;
    logic [31:0] r_perf_pf_drop;
    logic [31:0] r_perf_full;

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_merge   <= '0;
            r_perf_pf_drop <= '0;
            r_perf_full    <= '0;
        end else begin
            if (dmd_valid_i && (|w_dmd_hit) && r_perf_merge != '1) begin
                r_perf_merge <= r_perf_merge + 32'd1;
            end
            if (pf_valid_i && w_pf_ready && !w_pf_alloc && r_perf_pf_drop != '1) begin
                r_perf_pf_drop <= r_perf_pf_drop + 32'd1;
            end
            if (dmd_valid_i && !w_dmd_ready && r_perf_full != '1) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
        end
    end

    assign perf_merge_o   = r_perf_merge;
    assign perf_pf_drop_o = r_perf_pf_drop;
    assign perf_full_o    = r_perf_full;
`endif

endmodule

// File: tb/tb_icache_miss_queue.sv
// Self-checking bench for icache_miss_queue: directed scenarios followed by random traffic,
// all checked against a FIFO-of-lines reference model.
module tb_icache_miss_queue;

    localparam int unsigned PLEN   = 32;
    localparam int unsigned LW     = 512;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned OFS    = 6;
    localparam int unsigned LINE_W = PLEN - OFS;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            dmd_valid_i;
    logic            dmd_ready_o;
    logic [PLEN-1:0] dmd_addr_i;
    logic            pf_valid_i;
    logic            pf_ready_o;
    logic [PLEN-1:0] pf_addr_i;
    logic            mem_req_valid_o;
    logic            mem_req_ready_i;
    logic [PLEN-1:0] mem_req_addr_o;
    logic            mem_req_pf_o;
    logic            mem_rsp_valid_i;
    logic [LW-1:0]   mem_rsp_data_i;
    logic            refill_valid_o;
    logic [PLEN-1:0] refill_addr_o;
    logic [LW-1:0]   refill_data_o;
    logic            refill_pf_o;
    logic            busy_o;
`ifdef ICACHE_MISS_Q_PERF_EN
    logic [31:0]     perf_merge_o;
    logic [31:0]     perf_pf_drop_o;
    logic [31:0]     perf_full_o;
`endif

    always #5 clk_i = ~clk_i;

    icache_miss_queue #(
        .PLEN       (PLEN),
        .LINE_WIDTH (LW),
        .DEPTH      (DEPTH),
        .OFFSET_W   (OFS)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .dmd_valid_i     (dmd_valid_i),
        .dmd_ready_o     (dmd_ready_o),
        .dmd_addr_i      (dmd_addr_i),
        .pf_valid_i      (pf_valid_i),
        .pf_ready_o      (pf_ready_o),
        .pf_addr_i       (pf_addr_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_pf_o    (mem_req_pf_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .refill_valid_o  (refill_valid_o),
        .refill_addr_o   (refill_addr_o),
        .refill_data_o   (refill_data_o),
        .refill_pf_o     (refill_pf_o),
        .busy_o          (busy_o)
`ifdef ICACHE_MISS_Q_PERF_EN
        ,
        .perf_merge_o    (perf_merge_o),
        .perf_pf_drop_o  (perf_pf_drop_o),
        .perf_full_o     (perf_full_o)
`endif
    );

    typedef struct {
        logic [LINE_W-1:0] line;
        logic              pf;
        logic              issued;
        int                alloc_edge;
    } ent_t;

    ent_t            mq[$];
    int              n_checks = 0;
    int              n_errors = 0;
    int              edge_cnt = 0;
    int              n_hs = 0;
    logic            exp_req_valid_q = 1'b0;

    logic            obs_dmd_rdy;
    logic            obs_pf_rdy;
    logic            obs_req_valid;
    logic [PLEN-1:0] obs_req_addr;
    logic            obs_req_pf;
    logic            obs_refill_valid;
    logic [PLEN-1:0] obs_refill_addr;
    logic [LW-1:0]   obs_refill_data;
    logic            obs_refill_pf;
    logic            obs_busy;

    task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oldest_unissued();
        for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].issued) return i;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check readies, advance the model at the edge, check outputs.
    task automatic cycle(input logic dv, input logic [PLEN-1:0] da, input logic pv,
                         input logic [PLEN-1:0] pa, input logic mrdy, input logic rv,
                         input logic [LW-1:0] rd);
        logic              fire;
        int                dhit;
        int                phit;
        int                nfree;
        int                ui;
        logic              exp_drdy;
        logic              exp_prdy;
        logic              exp_rv;
        logic [PLEN-1:0]   exp_ra;
        logic              exp_rpf;
        ent_t              e;
        dmd_valid_i     = dv;
        dmd_addr_i      = da;
        pf_valid_i      = pv;
        pf_addr_i       = pa;
        mem_req_ready_i = mrdy;
        mem_rsp_valid_i = rv;
        mem_rsp_data_i  = rd;
        #1;
        fire = rv && (mq.size() > 0) && mq[0].issued;
        dhit = -1;
        phit = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (!(fire && i == 0)) begin
                if (mq[i].line == da[PLEN-1:OFS]) dhit = i;
                if (mq[i].line == pa[PLEN-1:OFS]) phit = i;
            end
        end
        nfree    = DEPTH - mq.size() + (fire ? 1 : 0);
        exp_drdy = (dhit >= 0) || (nfree >= 1);
        if (dv) exp_prdy = (pa[PLEN-1:OFS] == da[PLEN-1:OFS]) && exp_drdy;
        else    exp_prdy = (phit >= 0) || (nfree >= 2);
        obs_dmd_rdy = dmd_ready_o;
        obs_pf_rdy  = pf_ready_o;
        check_val("dmd_ready", dmd_ready_o, exp_drdy);
        check_val("pf_ready", pf_ready_o, exp_prdy);

        @(posedge clk_i);
        edge_cnt++;
        if (exp_req_valid_q && mrdy) begin
            ui = oldest_unissued();
            mq[ui].issued = 1'b1;
            n_hs++;
        end
        if (dv && dhit >= 0) mq[dhit].pf = 1'b0;
        exp_rv  = fire;
        exp_ra  = '0;
        exp_rpf = 1'b0;
        if (fire) begin
            exp_ra  = {mq[0].line, {OFS{1'b0}}};
            exp_rpf = mq[0].pf;
            void'(mq.pop_front());
        end
        e.issued     = 1'b0;
        e.alloc_edge = edge_cnt;
        if (dv && dhit < 0 && nfree >= 1) begin
            e.line = da[PLEN-1:OFS];
            e.pf   = 1'b0;
            mq.push_back(e);
        end else if (!dv && pv && phit < 0 && nfree >= 2) begin
            e.line = pa[PLEN-1:OFS];
            e.pf   = 1'b1;
            mq.push_back(e);
        end

        #1;
        ui = oldest_unissued();
        exp_req_valid_q = (ui >= 0) && (mq[ui].alloc_edge < edge_cnt);
        check_val("mem_req_valid", mem_req_valid_o, exp_req_valid_q);
        if (exp_req_valid_q) check_val("mem_req_addr", mem_req_addr_o, {mq[ui].line, {OFS{1'b0}}});
        check_val("refill_valid", refill_valid_o, exp_rv);
        if (exp_rv) begin
            check_val("refill_addr", refill_addr_o, exp_ra);
            check_val("refill_data", refill_data_o, rd);
            check_val("refill_pf", refill_pf_o, exp_rpf);
        end
        check_val("busy", busy_o, mq.size() != 0);
        obs_req_valid    = mem_req_valid_o;
        obs_req_addr     = mem_req_addr_o;
        obs_req_pf       = mem_req_pf_o;
        obs_refill_valid = refill_valid_o;
        obs_refill_addr  = refill_addr_o;
        obs_refill_data  = refill_data_o;
        obs_refill_pf    = refill_pf_o;
        obs_busy         = busy_o;
    endtask

    task automatic idle(input logic mrdy);
        cycle(1'b0, '0, 1'b0, '0, mrdy, 1'b0, '0);
    endtask

    task automatic rsp(input logic [LW-1:0] rd);
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, rd);
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        dmd_valid_i     = 1'b0;
        dmd_addr_i      = '0;
        pf_valid_i      = 1'b0;
        pf_addr_i       = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        @(posedge clk_i);
        edge_cnt++;
        mq.delete();
        exp_req_valid_q = 1'b0;
        #1;
        check_val("rst_busy", busy_o, 1'b0);
        check_val("rst_req_valid", mem_req_valid_o, 1'b0);
        check_val("rst_req_addr", mem_req_addr_o, '0);
        check_val("rst_req_pf", mem_req_pf_o, 1'b0);
        check_val("rst_refill_valid", refill_valid_o, 1'b0);
        check_val("rst_refill_addr", refill_addr_o, '0);
        check_val("rst_refill_data", refill_data_o, '0);
        check_val("rst_refill_pf", refill_pf_o, 1'b0);
        check_val("rst_dmd_ready", dmd_ready_o, 1'b1);
        check_val("rst_pf_ready", pf_ready_o, 1'b1);
`ifdef ICACHE_MISS_Q_PERF_EN
        check_val("rst_perf_merge", perf_merge_o, '0);
        check_val("rst_perf_pf_drop", perf_pf_drop_o, '0);
        check_val("rst_perf_full", perf_full_o, '0);
`endif
        rst_i = 1'b0;
    endtask

    function automatic logic [PLEN-1:0] rand_addr();
        return 32'h8000_0000 + (32'($urandom_range(0, 5)) << OFS) + 32'($urandom_range(0, 63));
    endfunction

    initial begin
        logic [LW-1:0] data_a;
        logic [LW-1:0] data_b;
        logic [LW-1:0] rd;
        for (int k = 0; k < LW / 32; k++) begin
            data_a[k*32 +: 32] = $urandom;
            data_b[k*32 +: 32] = $urandom;
        end

        // Single demand: request next cycle, refill one cycle after response.
        do_reset();
        cycle(1'b1, 32'h8000_0044, 1'b0, '0, 1'b1, 1'b0, '0);
        idle(1'b1);
        check_val("t1_req_valid", obs_req_valid, 1'b1);
        check_val("t1_req_addr", obs_req_addr, 32'h8000_0040);
        check_val("t1_req_pf", obs_req_pf, 1'b0);
        idle(1'b1);
        rsp(data_a);
        check_val("t1_refill_valid", obs_refill_valid, 1'b1);
        check_val("t1_refill_addr", obs_refill_addr, 32'h8000_0040);
        check_val("t1_refill_data", obs_refill_data, data_a);
        idle(1'b0);
        check_val("t1_refill_pulse", obs_refill_valid, 1'b0);

        // Demand hitting a queued prefetch: one request, upgraded refill.
        do_reset();
        n_hs = 0;
        cycle(1'b0, '0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h0000_1020, 1'b0, '0, 1'b1, 1'b0, '0);
        check_val("t2_dmd_merge", obs_dmd_rdy, 1'b1);
        idle(1'b1);
        idle(1'b1);
        rsp(data_b);
        check_val("t2_refill_pf", obs_refill_pf, 1'b0);
        check_val("t2_refill_addr", obs_refill_addr, 32'h0000_1000);
        check_val("t2_one_req", n_hs, 1);

        // Reserved demand slot and full queue.
        do_reset();
        cycle(1'b1, 32'h0000_0100, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h0000_0200, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h0000_0300, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b1, 32'h0000_0400, 1'b0, 1'b0, '0);
        check_val("t3_pf_last_slot", obs_pf_rdy, 1'b0);
        cycle(1'b1, 32'h0000_0400, 1'b0, '0, 1'b0, 1'b0, '0);
        check_val("t3_dmd_last_slot", obs_dmd_rdy, 1'b1);
        cycle(1'b1, 32'h0000_0500, 1'b0, '0, 1'b0, 1'b0, '0);
        check_val("t3_dmd_full", obs_dmd_rdy, 1'b0);
        cycle(1'b0, '0, 1'b1, 32'h0000_0120, 1'b0, 1'b0, '0);
        check_val("t3_pf_merge_full", obs_pf_rdy, 1'b1);

        // Same-cycle demand and prefetch.
        do_reset();
        cycle(1'b1, 32'h0000_2000, 1'b1, 32'h0000_2010, 1'b0, 1'b0, '0);
        check_val("t4_dmd_ready", obs_dmd_rdy, 1'b1);
        check_val("t4_pf_same_line", obs_pf_rdy, 1'b1);
        cycle(1'b1, 32'h0000_5000, 1'b1, 32'h0000_3000, 1'b0, 1'b0, '0);
        check_val("t4_pf_other_line", obs_pf_rdy, 1'b0);

        // In-order refills and a response on an empty queue.
        do_reset();
        cycle(1'b1, 32'h0000_A000, 1'b0, '0, 1'b1, 1'b0, '0);
        cycle(1'b1, 32'h0000_B000, 1'b0, '0, 1'b1, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);
        rsp(data_a);
        check_val("t5_refill_a_addr", obs_refill_addr, 32'h0000_A000);
        check_val("t5_refill_a_data", obs_refill_data, data_a);
        rsp(data_b);
        check_val("t5_refill_b_addr", obs_refill_addr, 32'h0000_B000);
        check_val("t5_refill_b_data", obs_refill_data, data_b);
        rsp(data_a);
        check_val("t5_empty_rsp", obs_refill_valid, 1'b0);

        // Reset with two issued lines; late response is ignored.
        do_reset();
        cycle(1'b1, 32'h0000_C000, 1'b0, '0, 1'b1, 1'b0, '0);
        cycle(1'b1, 32'h0000_D000, 1'b0, '0, 1'b1, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);
        check_val("t6_busy_before", obs_busy, 1'b1);
        do_reset();
        rsp(data_a);
        check_val("t6_late_rsp", obs_refill_valid, 1'b0);
        check_val("t6_busy_after", obs_busy, 1'b0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < LW / 32; k++) rd[k*32 +: 32] = $urandom;
            cycle(($urandom % 3) == 0, rand_addr(), ($urandom % 3) == 0, rand_addr(),
                  ($urandom % 2) == 0, ($urandom % 3) == 0, rd);
            if (n % 1000 == 999) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
